// File: rtl/turn_controller.sv
// turn_controller: turn-sequencing FSM for the Chicken Cha Cha Cha board.
// Accepts card flips, strobes the data path's match check (A) and win check (B),
// reacts to go/W, and tracks the face-up mask for the current turn.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no game running, waiting for start
// WAIT   | waiting for a legal flip from the current player
// CHK    | A strobe, data path compares the flipped card
// EVAL   | sample go (match result)
// WCHK   | B strobe, data path checks for a win
// WEVAL  | sample W (win result)
// REVEAL | mismatched card stays face up for REVEAL_CYCLES cycles
// WIN    | game over, board frozen until start
module turn_controller #(
    parameter int NUM_CARDS     = 12,
    parameter int REVEAL_CYCLES = 50_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 flip,
    input  logic [3:0]           card_sel,
    input  logic                 go,
    input  logic                 W,
    output logic                 A,
    output logic                 B,
    output logic [3:0]           position_data,
    output logic                 statecombo_next_turn,
    output logic [NUM_CARDS-1:0] face_up,
    output logic [2:0]           state,
    output logic                 game_over
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_CHK    = 3'd2,
        S_EVAL   = 3'd3,
        S_WCHK   = 3'd4,
        S_WEVAL  = 3'd5,
        S_REVEAL = 3'd6,
        S_WIN    = 3'd7
    } state_t;

    localparam int CNT_W = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REVEAL_CYCLES - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_CARDS-1:0] face_up_q, face_up_d;
    logic [3:0]           pos_q, pos_d;
    logic                 a_q, a_d;
    logic                 b_q, b_d;
    logic                 next_turn_q, next_turn_d;
    logic                 game_over_q, game_over_d;

    logic [NUM_CARDS-1:0] sel_mask;
    logic                 accept;
    logic                 next_turn_action;
    logic                 clear_face;

    // One-hot decode of card_sel; out-of-range selects decode to all zeros
    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < NUM_CARDS; i++) begin
            if (card_sel == 4'(i)) sel_mask[i] = 1'b1;
        end
    end

    assign accept = flip && (state_q == S_WAIT) && (|sel_mask) && !(|(sel_mask & face_up_q));

    // State and output registers, all cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            face_up_q   <= '0;
            pos_q       <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            next_turn_q <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            face_up_q   <= face_up_d;
            pos_q       <= pos_d;
            a_q         <= a_d;
            b_q         <= b_d;
            next_turn_q <= next_turn_d;
            game_over_q <= game_over_d;
        end
    end

    // Next-state logic; flags the turn hand-over and the post-win board clear
    always_comb begin
        state_d          = state_q;
        next_turn_action = 1'b0;
        clear_face       = 1'b0;
        case (state_q)
            S_IDLE:   if (start) state_d = S_WAIT;
            S_WAIT:   if (accept) state_d = S_CHK;
            S_CHK:    state_d = S_EVAL;
            S_EVAL:   state_d = go ? S_WCHK : S_REVEAL;
            S_WCHK:   state_d = S_WEVAL;
            S_WEVAL: begin
                if (W) begin
                    state_d = S_WIN;
                end else begin
                    state_d          = S_WAIT;
                    next_turn_action = &face_up_q;
                end
            end
            S_REVEAL: begin
                if (cnt_q == CNT_LAST) begin
                    state_d          = S_WAIT;
                    next_turn_action = 1'b1;
                end
            end
            S_WIN: begin
                if (start) begin
                    state_d    = S_WAIT;
                    clear_face = 1'b1;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // Registered outputs derived from the upcoming state so strobes line up with it
    always_comb begin
        a_d         = (state_d == S_CHK);
        b_d         = (state_d == S_WCHK);
        game_over_d = (state_d == S_WIN);
        next_turn_d = next_turn_action;
        pos_d       = accept ? card_sel : pos_q;
        if (next_turn_action || clear_face) begin
            face_up_d = '0;
        end else if (accept) begin
            face_up_d = face_up_q | sel_mask;
        end else begin
            face_up_d = face_up_q;
        end
        cnt_d = (state_q == S_REVEAL && state_d == S_REVEAL) ? cnt_q + 1'b1 : '0;
    end

    assign A                    = a_q;
    assign B                    = b_q;
    assign position_data        = pos_q;
    assign statecombo_next_turn = next_turn_q;
    assign face_up              = face_up_q;
    assign state                = state_q;
    assign game_over            = game_over_q;

endmodule
